// File: rtl/bf_exec_controller.sv
// Brainfuck instruction sequencer: fetches program bytes, issues data-pointer
// strobes and cell read-modify-writes, runs the I/O handshakes and bracket scans.
module bf_exec_controller #(
  parameter int PADR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PADR_W-1:0] p_adr,
  input  logic [7:0]        p_data,
  output logic              ptr_inc,
  output logic              ptr_dec,
  output logic              ptr_clr,
  input  logic [DATA_W-1:0] d_rd_data,
  output logic              d_wr_en,
  output logic [DATA_W-1:0] d_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_OUT, S_IN,
    S_SF_FETCH, S_SF_CHK, S_SB_FETCH, S_SB_CHK,
    S_HALT, S_ERROR
  } state_t;

  localparam logic [7:0] CMD_RIGHT = 8'h3E;
  localparam logic [7:0] CMD_LEFT  = 8'h3C;
  localparam logic [7:0] CMD_PLUS  = 8'h2B;
  localparam logic [7:0] CMD_MINUS = 8'h2D;
  localparam logic [7:0] CMD_OUT   = 8'h2E;
  localparam logic [7:0] CMD_IN    = 8'h2C;
  localparam logic [7:0] CMD_LOOP  = 8'h5B;
  localparam logic [7:0] CMD_BACK  = 8'h5D;
  localparam logic [7:0] CMD_END   = 8'h00;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t              state_q, state_d;
  logic [PADR_W-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [DATA_W-1:0]   out_q, out_d;

  logic                clr_req;
  logic                pc_end;
  logic                pc_first;
  logic                depth_full;
  logic                cell_zero;
  logic [PADR_W-1:0]   pc_adv;
  state_t              adv_state;

  function automatic logic [DATA_W-1:0] cell_inc(input logic [DATA_W-1:0] v);
    return v + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] cell_dec(input logic [DATA_W-1:0] v);
    return v - DATA_W'(1);
  endfunction

  // Stepping past the last program address terminates instead of wrapping.
  assign pc_end     = &pc_q;
  assign pc_first   = (pc_q == '0);
  assign pc_adv     = pc_end ? pc_q : pc_q + PADR_W'(1);
  assign adv_state  = pc_end ? S_HALT : S_FETCH;
  assign depth_full = &depth_q;
  assign cell_zero  = (d_rd_data == '0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    depth_d   = depth_q;
    out_d     = out_q;
    clr_req   = 1'b0;
    ptr_inc   = 1'b0;
    ptr_dec   = 1'b0;
    d_wr_en   = 1'b0;
    d_wr_data = '0;
    out_valid = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          clr_req = 1'b1;
          pc_d    = '0;
          depth_d = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: state_d = S_EXEC;

      S_EXEC: begin
        pc_d    = pc_adv;
        state_d = adv_state;
        case (p_data)
          CMD_RIGHT: ptr_inc = 1'b1;
          CMD_LEFT:  ptr_dec = 1'b1;
          CMD_PLUS: begin
            d_wr_en   = 1'b1;
            d_wr_data = cell_inc(d_rd_data);
          end
          CMD_MINUS: begin
            d_wr_en   = 1'b1;
            d_wr_data = cell_dec(d_rd_data);
          end
          CMD_OUT: begin
            pc_d    = pc_q;
            out_d   = d_rd_data;
            state_d = S_OUT;
          end
          CMD_IN: begin
            pc_d    = pc_q;
            state_d = S_IN;
          end
          CMD_LOOP: begin
            if (cell_zero) begin
              depth_d = DEPTH_ONE;
              state_d = pc_end ? S_HALT : S_SF_FETCH;
            end
          end
          CMD_BACK: begin
            if (!cell_zero) begin
              depth_d = DEPTH_ONE;
              if (pc_first) begin
                pc_d    = pc_q;
                state_d = S_ERROR;
              end else begin
                pc_d    = pc_q - PADR_W'(1);
                state_d = S_SB_FETCH;
              end
            end
          end
          CMD_END: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end

      // out_data comes from out_q, so it stays put for the whole wait.
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_d    = pc_adv;
          state_d = adv_state;
        end
      end

      S_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          d_wr_en   = 1'b1;
          d_wr_data = in_data;
          pc_d      = pc_adv;
          state_d   = adv_state;
        end
      end

      S_SF_FETCH: state_d = S_SF_CHK;

      S_SF_CHK: begin
        pc_d    = pc_adv;
        state_d = pc_end ? S_HALT : S_SF_FETCH;
        case (p_data)
          CMD_LOOP: begin
            if (depth_full) begin
              pc_d    = pc_q;
              state_d = S_ERROR;
            end else begin
              depth_d = depth_q + DEPTH_W'(1);
            end
          end
          CMD_BACK: begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_q == DEPTH_ONE) state_d = adv_state;
          end
          CMD_END: begin
            pc_d    = pc_q;
            state_d = S_ERROR;
          end
          default: ;
        endcase
      end

      S_SB_FETCH: state_d = S_SB_CHK;

      // Walking backwards off address 0 means the ']' has no partner.
      S_SB_CHK: begin
        pc_d    = pc_first ? pc_q : pc_q - PADR_W'(1);
        state_d = pc_first ? S_ERROR : S_SB_FETCH;
        case (p_data)
          CMD_BACK: begin
            if (depth_full) begin
              pc_d    = pc_q;
              state_d = S_ERROR;
            end else begin
              depth_d = depth_q + DEPTH_W'(1);
            end
          end
          CMD_LOOP: begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_q == DEPTH_ONE) begin
              pc_d    = pc_adv;
              state_d = adv_state;
            end
          end
          default: ;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      depth_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      out_q   <= out_d;
    end
  end

  // Gated so a start held during reset cannot leak a clear strobe.
  assign ptr_clr  = clr_req & rst_n;
  assign p_adr    = pc_q;
  assign out_data = out_q;
  assign halted   = (state_q == S_HALT);
  assign error    = (state_q == S_ERROR);
  assign busy     = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR));

endmodule
